// File: rtl/lc3_writeback_regfile_if.sv
// Writeback/regfile bus bundle between the result path and the LC3 writeback stage.
// Ports (slave side = regfile):
//   enable_writeback, wb_we, wb_dest, wb_data, psr_update : writeback request
//   sr_addr                                             : packed read addresses
//   VSR, psr                                            : registered read data and {N,Z,P}
//   sb_set, sb_set_addr, busy                           : busy scoreboard (WB_SCOREBOARD_EN only)
// Optional feature macro: WB_SCOREBOARD_EN
interface lc3_writeback_regfile_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned NUM_RD = 2
);
    logic                       enable_writeback;
    logic                       wb_we;
    logic [ADDR_W-1:0]          wb_dest;
    logic [DATA_W-1:0]          wb_data;
    logic                       psr_update;
    logic [NUM_RD*ADDR_W-1:0]   sr_addr;
    logic [NUM_RD*DATA_W-1:0]   VSR;
    logic [2:0]                 psr;
`ifdef WB_SCOREBOARD_EN
    logic                       sb_set;
    logic [ADDR_W-1:0]          sb_set_addr;
    logic [NUM_RD-1:0]          busy;

    modport master (
        output enable_writeback, wb_we, wb_dest, wb_data, psr_update, sr_addr,
               sb_set, sb_set_addr,
        input  VSR, psr, busy
    );
    modport slave (
        input  enable_writeback, wb_we, wb_dest, wb_data, psr_update, sr_addr,
               sb_set, sb_set_addr,
        output VSR, psr, busy
    );
`else
    modport master (
        output enable_writeback, wb_we, wb_dest, wb_data, psr_update, sr_addr,
        input  VSR, psr
    );
    modport slave (
        input  enable_writeback, wb_we, wb_dest, wb_data, psr_update, sr_addr,
        output VSR, psr
    );
`endif
endinterface

// File: rtl/lc3_writeback_regfile.sv
// LC3 writeback stage: register file with NUM_RD registered read ports and N/Z/P psr.
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous active-high reset
//   wb     : lc3_writeback_regfile_if.slave (writeback request, reads, psr, scoreboard)
// Optional feature macro: WB_SCOREBOARD_EN adds a per-register busy scoreboard
// whose state is reported per read port, aligned with VSR.
module lc3_writeback_regfile #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned NUM_RD      = 2,
    parameter int unsigned WRITE_FIRST = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    lc3_writeback_regfile_if.slave    wb
);
    localparam int unsigned VSR_W = NUM_RD * DATA_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [VSR_W-1:0]  vsr_q, vsr_d;
    logic [2:0]        psr_q, psr_d;
    logic              wr_active;
    logic [ADDR_W-1:0] rd_addr;

    assign wr_active = wb.enable_writeback && wb.wb_we;

    // Next register contents and psr.
    always_comb begin
        regs_d = regs_q;
        psr_d  = psr_q;
        if (wr_active) begin
            regs_d[wb.wb_dest] = wb.wb_data;
        end
        if (wb.enable_writeback && wb.psr_update) begin
            if (wb.wb_data[DATA_W-1]) begin
                psr_d = 3'b100;
            end else if (wb.wb_data == '0) begin
                psr_d = 3'b010;
            end else begin
                psr_d = 3'b001;
            end
        end
    end

    // Reads are ungated; write-first ports see the post-write array.
    always_comb begin
        vsr_d   = '0;
        rd_addr = '0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            rd_addr = wb.sr_addr[i*ADDR_W +: ADDR_W];
            if (WRITE_FIRST != 0) begin
                vsr_d[i*DATA_W +: DATA_W] = regs_d[rd_addr];
            end else begin
                vsr_d[i*DATA_W +: DATA_W] = regs_q[rd_addr];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < int'(NUM_REGS); k++) begin
                regs_q[k] <= '0;
            end
            vsr_q <= '0;
            psr_q <= 3'b010;
        end else begin
            regs_q <= regs_d;
            vsr_q  <= vsr_d;
            psr_q  <= psr_d;
        end
    end

    assign wb.VSR = vsr_q;
    assign wb.psr = psr_q;

`ifdef WB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] sb_q, sb_d;
    logic [NUM_RD-1:0]   busy_q, busy_d;
    logic [ADDR_W-1:0]   sb_rd_addr;

    // Clear on write first so a same-register set wins.
    always_comb begin
        sb_d       = sb_q;
        busy_d     = '0;
        sb_rd_addr = '0;
        if (wb.enable_writeback) begin
            if (wb.wb_we) begin
                sb_d[wb.wb_dest] = 1'b0;
            end
            if (wb.sb_set) begin
                sb_d[wb.sb_set_addr] = 1'b1;
            end
        end
        for (int i = 0; i < int'(NUM_RD); i++) begin
            sb_rd_addr = wb.sr_addr[i*ADDR_W +: ADDR_W];
            busy_d[i]  = sb_d[sb_rd_addr];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sb_q   <= '0;
            busy_q <= '0;
        end else begin
            sb_q   <= sb_d;
            busy_q <= busy_d;
        end
    end

    assign wb.busy = busy_q;
`endif

endmodule

// File: tb/tb_lc3_writeback_regfile.sv
// Bench for lc3_writeback_regfile: a write-first and a read-first instance share
// the same stimulus and are checked every cycle against an array-based model.
module tb_lc3_writeback_regfile;
    localparam int unsigned DW = 16;
    localparam int unsigned NR = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned ND = 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic          en, we, pupd, sb_set;
    logic [AW-1:0] dest, sb_addr;
    logic [DW-1:0] data;
    logic [ND*AW-1:0] sr_addr;

    lc3_writeback_regfile_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(ND)) if_wf1 ();
    lc3_writeback_regfile_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(ND)) if_wf0 ();

    assign if_wf1.enable_writeback = en;
    assign if_wf1.wb_we            = we;
    assign if_wf1.wb_dest          = dest;
    assign if_wf1.wb_data          = data;
    assign if_wf1.psr_update       = pupd;
    assign if_wf1.sr_addr          = sr_addr;
    assign if_wf0.enable_writeback = en;
    assign if_wf0.wb_we            = we;
    assign if_wf0.wb_dest          = dest;
    assign if_wf0.wb_data          = data;
    assign if_wf0.psr_update       = pupd;
    assign if_wf0.sr_addr          = sr_addr;
`ifdef WB_SCOREBOARD_EN
    assign if_wf1.sb_set      = sb_set;
    assign if_wf1.sb_set_addr = sb_addr;
    assign if_wf0.sb_set      = sb_set;
    assign if_wf0.sb_set_addr = sb_addr;
`endif

    lc3_writeback_regfile #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(ND), .WRITE_FIRST(1))
        u_wf1 (.clock(clock), .reset(reset), .wb(if_wf1));
    lc3_writeback_regfile #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(ND), .WRITE_FIRST(0))
        u_wf0 (.clock(clock), .reset(reset), .wb(if_wf0));

    // ---------------- model ----------------
    logic [DW-1:0] m_regs [NR];
    logic [NR-1:0] m_sb;
    logic [2:0]    m_psr;
    logic [DW-1:0] exp_vsr1 [ND];
    logic [DW-1:0] exp_vsr0 [ND];
    logic [ND-1:0] exp_busy;
    logic [AW-1:0] m_a;
    logic          m_wr;
    logic          chk_en = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < int'(NR); r++) m_regs[r] = '0;
            for (int i = 0; i < int'(ND); i++) begin
                exp_vsr1[i] = '0;
                exp_vsr0[i] = '0;
            end
            m_sb     = '0;
            exp_busy = '0;
            m_psr    = 3'b010;
            chk_en   = 1'b1;
        end else begin
            m_wr = en && we;
            for (int i = 0; i < int'(ND); i++) begin
                m_a         = sr_addr[i*AW +: AW];
                exp_vsr0[i] = m_regs[m_a];
                exp_vsr1[i] = (m_wr && m_a == dest) ? data : m_regs[m_a];
                if (en && sb_set && m_a == sb_addr)  exp_busy[i] = 1'b1;
                else if (m_wr && m_a == dest)        exp_busy[i] = 1'b0;
                else                                 exp_busy[i] = m_sb[m_a];
            end
            if (m_wr) m_regs[dest] = data;
            if (en && pupd) begin
                if ($signed(data) < 0)  m_psr = 3'b100;
                else if (data == 0)     m_psr = 3'b010;
                else                    m_psr = 3'b001;
            end
            if (en) begin
                if (m_wr)   m_sb[dest]    = 1'b0;
                if (sb_set) m_sb[sb_addr] = 1'b1;
            end
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            for (int i = 0; i < int'(ND); i++) begin
                chk($sformatf("vsr_wf1[%0d]", i), 64'(if_wf1.VSR[i*DW +: DW]), 64'(exp_vsr1[i]));
                chk($sformatf("vsr_wf0[%0d]", i), 64'(if_wf0.VSR[i*DW +: DW]), 64'(exp_vsr0[i]));
            end
            chk("psr_wf1", 64'(if_wf1.psr), 64'(m_psr));
            chk("psr_wf0", 64'(if_wf0.psr), 64'(m_psr));
`ifdef WB_SCOREBOARD_EN
            chk("busy_wf1", 64'(if_wf1.busy), 64'(exp_busy));
            chk("busy_wf0", 64'(if_wf0.busy), 64'(exp_busy));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic en_i, input logic we_i, input logic [AW-1:0] d_i,
                        input logic [DW-1:0] dat_i, input logic pu_i,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic sb_i, input logic [AW-1:0] sba_i);
        en = en_i; we = we_i; dest = d_i; data = dat_i; pupd = pu_i;
        sr_addr = {a1, a0};
        sb_set = sb_i; sb_addr = sba_i;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic randomize_inputs();
        en = 1'($urandom); we = 1'($urandom); dest = AW'($urandom); data = DW'($urandom);
        pupd = 1'($urandom); sr_addr = (ND*AW)'($urandom);
        sb_set = 1'($urandom); sb_addr = AW'($urandom);
    endtask

    initial begin
        reset = 1'b1;
        randomize_inputs();
        @(posedge clock); @(negedge clock);
        randomize_inputs();
        @(posedge clock); @(negedge clock);
        reset = 1'b0;

        // reset values visible after release
        step(1, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
        chk("rst_vsr", 64'(if_wf1.VSR), 64'h0);
        chk("rst_psr", 64'(if_wf1.psr), 64'h2);
`ifdef WB_SCOREBOARD_EN
        chk("rst_busy", 64'(if_wf1.busy), 64'h0);
`endif

        // negative write sets N, then read back
        step(1, 1, 3, 16'h8001, 1, 0, 0, 0, 0);
        chk("psr_neg", 64'(if_wf1.psr), 64'h4);
        step(1, 0, 0, 16'h0000, 0, 3, 0, 0, 0);
        chk("rd_r3", 64'(if_wf1.VSR[15:0]), 64'h8001);
        chk("rd_r3_wf0", 64'(if_wf0.VSR[15:0]), 64'h8001);
        step(1, 1, 4, 16'h0000, 1, 0, 0, 0, 0);
        chk("psr_zero", 64'(if_wf1.psr), 64'h2);

        // same-cycle write and read: bypass vs old value
        step(1, 1, 5, 16'h0042, 0, 0, 0, 0, 0);
        step(1, 1, 5, 16'h1234, 0, 5, 5, 0, 0);
        chk("byp_wf1", 64'(if_wf1.VSR), 64'h1234_1234);
        chk("old_wf0", 64'(if_wf0.VSR), 64'h0042_0042);

        // disabled stage: no state change, reads continue
        step(0, 1, 2, 16'hBEEF, 1, 2, 5, 0, 0);
        chk("dis_psr", 64'(if_wf1.psr), 64'h2);
        chk("dis_rd", 64'(if_wf1.VSR), 64'h1234_0000);
        step(1, 0, 0, 16'h0000, 0, 2, 3, 0, 0);
        chk("dis_r2", 64'(if_wf0.VSR), 64'h8001_0000);

`ifdef WB_SCOREBOARD_EN
        step(1, 0, 0, 16'h0000, 0, 1, 0, 1, 1);
        chk("sb_set", 64'(if_wf1.busy[0]), 64'h1);
        step(1, 1, 1, 16'h0077, 0, 1, 0, 1, 1);
        chk("sb_set_wins", 64'(if_wf1.busy[0]), 64'h1);
        step(1, 1, 1, 16'h0055, 0, 1, 0, 0, 0);
        chk("sb_clr", 64'(if_wf1.busy[0]), 64'h0);
        chk("sb_clr_data", 64'(if_wf1.VSR[15:0]), 64'h0055);
        chk("sb_clr_wf0", 64'(if_wf0.VSR[15:0]), 64'h0077);
        step(1, 0, 0, 16'h0000, 0, 0, 0, 1, 7);
`endif

        // positive write, then reset mid-stream with activity on the inputs
        step(1, 1, 6, 16'h0007, 1, 6, 3, 0, 0);
        chk("psr_pos", 64'(if_wf1.psr), 64'h1);
        reset = 1'b1;
        step(1, 1, 6, 16'h8888, 1, 7, 3, 1, 3);
        reset = 1'b0;
        chk("mrst_vsr", 64'(if_wf1.VSR), 64'h0);
        chk("mrst_psr", 64'(if_wf1.psr), 64'h2);
`ifdef WB_SCOREBOARD_EN
        chk("mrst_busy", 64'(if_wf1.busy), 64'h0);
`endif
        step(1, 0, 0, 16'h0000, 0, 3, 6, 0, 0);
        chk("mrst_regs", 64'(if_wf0.VSR), 64'h0);

        // mixed traffic checked by the model
        for (int n = 0; n < 40; n++) begin
            randomize_inputs();
`ifndef WB_SCOREBOARD_EN
            sb_set = 1'b0;
`endif
            @(posedge clock);
            @(negedge clock);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
